mult_seq_ctrl: RTL



---
 rtl/mult_seq_ctrl_pkg.sv | 21 ++
 rtl/mult_seq_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl_pkg
// Description : Shared types and constants for the bit-serial multiplier
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } mult_seq_state_t;

   localparam int         MULT_W         = 4;
   localparam logic [2:0] M_CTRL_NOWRITE = 3'b100;

endpackage
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Drives a 4-lane bit-serial AND multiplier one partial-product
//               row per pass and accumulates a full W x W product.
//               Define MULT_SEQ_CTRL_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
   import mult_seq_ctrl_pkg::*;
#(
   parameter int W = MULT_W
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           IN_VALID,
   output logic           IN_READY,
   input  logic [W-1:0]   OPA,
   input  logic [W-1:0]   OPB,
   output logic           MA,
   output logic           MB,
   output logic [2:0]     M_CTRL,
   input  logic [W-1:0]   PP,
   output logic [2*W-1:0] PROD,
   output logic           OUT_VALID
);

   localparam logic [1:0] c_LAST = 2'(W - 1);

   mult_seq_state_t r_state;
   mult_seq_state_t w_state_nxt;

   logic [1:0]     r_k;
   logic [1:0]     r_j;
   logic [W-1:0]   r_opa;
   logic [W-1:0]   r_opb;
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_prod;

   logic           w_accept;
   logic [1:0]     w_lane;
   logic [W-1:0]   w_opa_lat;
   logic [W-1:0]   w_opb_lat;
   logic [2*W-1:0] w_acc_nxt;
   logic [2*W-1:0] w_prod_fin;

   assign w_accept  = (r_state == ST_IDLE) && IN_VALID;
   assign w_lane    = c_LAST - r_k;
   assign w_acc_nxt = r_acc + ({{W{1'b0}}, PP} << r_j);

`ifdef MULT_SEQ_CTRL_SIGNED_EN
   logic r_sign;

   // Magnitudes are latched; the most negative value maps to its unsigned magnitude.
   assign w_opa_lat  = OPA[W-1] ? (~OPA + 1'b1) : OPA;
   assign w_opb_lat  = OPB[W-1] ? (~OPB + 1'b1) : OPB;
   assign w_prod_fin = r_sign ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sign <= 1'b0;
      end else if (w_accept) begin
         r_sign <= OPA[W-1] ^ OPB[W-1];
      end
   end
`else
   assign w_opa_lat  = OPA;
   assign w_opb_lat  = OPB;
   assign w_prod_fin = w_acc_nxt;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      IN_READY    = 1'b0;
      MA          = 1'b0;
      MB          = 1'b0;
      M_CTRL      = M_CTRL_NOWRITE;
      case (r_state)
         ST_IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A enters MSB first so that after four shifts lane i holds A[i].
            MA     = r_opa[w_lane];
            MB     = r_opb[r_j];
            M_CTRL = {1'b0, w_lane};
            if (r_k == c_LAST) begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            w_state_nxt = (r_j == c_LAST) ? ST_DONE : ST_LOAD;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_k    <= 2'd0;
         r_j    <= 2'd0;
         r_opa  <= '0;
         r_opb  <= '0;
         r_acc  <= '0;
         r_prod <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_opa <= w_opa_lat;
                  r_opb <= w_opb_lat;
                  r_acc <= '0;
                  r_j   <= 2'd0;
                  r_k   <= 2'd0;
               end
            end
            ST_LOAD: begin
               r_k <= r_k + 2'd1;
            end
            ST_SAMPLE: begin
               r_acc <= w_acc_nxt;
               // Final row: register the result so it is valid throughout DONE.
               if (r_j == c_LAST) begin
                  r_prod <= w_prod_fin;
               end else begin
                  r_j <= r_j + 2'd1;
                  r_k <= 2'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign PROD      = r_prod;
   assign OUT_VALID = (r_state == ST_DONE);

endmodule
`default_nettype wire
